// File: rtl/note_sequencer_if.sv
// Control/status bundle between the button/UART config logic and note_sequencer.
// The master side owns playback control and table writes; the slave side is
// the sequencer, which reports status and drives the buzzer pin.
interface note_sequencer_if #(
  parameter int N_NOTES = 8,
  parameter int DIV_W   = 16,
  parameter int DUR_W   = 8
);
  localparam int IDX_W = (N_NOTES > 1) ? $clog2(N_NOTES) : 1;

  logic             start;
  logic             stop;
  logic             loop;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_addr;
  logic [DIV_W-1:0] cfg_div;
  logic [DUR_W-1:0] cfg_dur;
  logic             busy;
  logic [IDX_W-1:0] note_idx;
  logic             done;
  logic             out;

  modport master (
    output start, stop, loop, cfg_we, cfg_addr, cfg_div, cfg_dur,
    input  busy, note_idx, done, out
  );

  modport slave (
    input  start, stop, loop, cfg_we, cfg_addr, cfg_div, cfg_dur,
    output busy, note_idx, done, out
  );
endinterface

// File: rtl/note_sequencer.sv
// note_sequencer: steps through a writable table of {half-period divisor,
// duration} entries and plays each one as a square wave on the buzzer pin.
// A divisor of 0 is a rest, a duration of 0 marks the end of the melody.
// Build option NOTE_GAP_EN: the last tick of every note lasting two or more
// ticks is silent, so repeated equal notes are heard as separate notes.
module note_sequencer #(
  parameter int N_NOTES  = 8,
  parameter int DIV_W    = 16,
  parameter int DUR_W    = 8,
  parameter int TICK_DIV = 12000
) (
  input  logic            clk,
  input  logic            rst,
  note_sequencer_if.slave bus
);
  localparam int IDX_W = (N_NOTES > 1) ? $clog2(N_NOTES) : 1;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NOTES - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

`ifdef NOTE_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY
  } state_t;

  state_t state_q, state_d;

  logic [DIV_W-1:0] tab_div_q [N_NOTES];
  logic [DUR_W-1:0] tab_dur_q [N_NOTES];

  logic [DIV_W-1:0] cur_div_q,  cur_div_d;
  logic [DUR_W-1:0] cur_dur_q,  cur_dur_d;
  logic [DIV_W-1:0] half_cnt_q, half_cnt_d;
  logic [PRE_W-1:0] presc_q,    presc_d;
  logic [DUR_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [IDX_W-1:0] note_idx_q, note_idx_d;
  logic             done_q,     done_d;
  logic             out_q,      out_d;

  logic [DIV_W-1:0] tab_rd_div;
  logic [DUR_W-1:0] tab_rd_dur;
  logic             tick_pulse;
  logic             last_note;
  logic             load_end;
  logic             note_end;
  logic             half_wrap;
  logic             in_gap;
  logic             enter_gap;

  // Entry being loaded is always the one addressed by the current note index.
  assign tab_rd_div = tab_div_q[note_idx_q];
  assign tab_rd_dur = tab_dur_q[note_idx_q];

  // Timing events; all compares are equality against the latched limits so
  // no counter ever has to wrap past its terminal value.
  assign tick_pulse = (presc_q == PRE_LAST);
  assign last_note  = (note_idx_q == LAST_IDX);
  assign load_end   = (state_q == S_LOAD) && (tab_rd_dur == '0);
  assign note_end   = (state_q == S_PLAY) && tick_pulse &&
                      (tick_cnt_q == cur_dur_q - DUR_W'(1));
  assign half_wrap  = (cur_div_q != '0) && (half_cnt_q == cur_div_q - DIV_W'(1));
  assign in_gap     = GAP_EN && (state_q == S_PLAY) && (cur_dur_q >= DUR_W'(2)) &&
                      (tick_cnt_q == cur_dur_q - DUR_W'(1));
  assign enter_gap  = GAP_EN && (state_q == S_PLAY) && (cur_dur_q >= DUR_W'(2)) &&
                      tick_pulse && (tick_cnt_q == cur_dur_q - DUR_W'(2));

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.note_idx = note_idx_q;
  assign bus.done     = done_q;
  assign bus.out      = out_q;

  // Note table write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (bus.cfg_we) begin
      tab_div_q[bus.cfg_addr] <= bus.cfg_div;
      tab_dur_q[bus.cfg_addr] <= bus.cfg_dur;
    end
  end

  // Playback state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: stop overrides everything, end of melody either loops or idles.
  always_comb begin
    state_d = state_q;
    if (bus.stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          if (load_end) begin
            state_d = bus.loop ? S_LOAD : S_IDLE;
          end else begin
            state_d = S_PLAY;
          end
        end
        S_PLAY: begin
          if (note_end) begin
            state_d = (last_note && !bus.loop) ? S_IDLE : S_LOAD;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next values: note latch, counters, square wave, index and done.
  always_comb begin
    cur_div_d  = cur_div_q;
    cur_dur_d  = cur_dur_q;
    half_cnt_d = half_cnt_q;
    presc_d    = presc_q;
    tick_cnt_d = tick_cnt_q;
    note_idx_d = note_idx_q;
    done_d     = 1'b0;
    out_d      = out_q;
    if (bus.stop) begin
      half_cnt_d = '0;
      presc_d    = '0;
      tick_cnt_d = '0;
      out_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          out_d = 1'b0;
          if (bus.start) begin
            note_idx_d = '0;
          end
        end
        S_LOAD: begin
          cur_div_d  = tab_rd_div;
          cur_dur_d  = tab_rd_dur;
          half_cnt_d = '0;
          presc_d    = '0;
          tick_cnt_d = '0;
          out_d      = 1'b0;
          if (load_end) begin
            if (bus.loop) begin
              note_idx_d = '0;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        S_PLAY: begin
          if (note_end) begin
            half_cnt_d = '0;
            presc_d    = '0;
            tick_cnt_d = '0;
            out_d      = 1'b0;
            if (!last_note) begin
              note_idx_d = note_idx_q + IDX_W'(1);
            end else if (bus.loop) begin
              note_idx_d = '0;
            end else begin
              done_d = 1'b1;
            end
          end else begin
            presc_d = tick_pulse ? '0 : presc_q + PRE_W'(1);
            if (tick_pulse) begin
              tick_cnt_d = tick_cnt_q + DUR_W'(1);
            end
            if (in_gap) begin
              out_d = 1'b0;
            end else begin
              if (cur_div_q == '0) begin
                half_cnt_d = '0;
                out_d      = 1'b0;
              end else if (half_wrap) begin
                half_cnt_d = '0;
                out_d      = ~out_q;
              end else begin
                half_cnt_d = half_cnt_q + DIV_W'(1);
              end
              if (enter_gap) begin
                out_d = 1'b0;
              end
            end
          end
        end
        default: begin
          out_d = 1'b0;
        end
      endcase
    end
  end

  // Datapath registers; the table itself is not part of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_div_q  <= '0;
      cur_dur_q  <= '0;
      half_cnt_q <= '0;
      presc_q    <= '0;
      tick_cnt_q <= '0;
      note_idx_q <= '0;
      done_q     <= 1'b0;
      out_q      <= 1'b0;
    end else begin
      cur_div_q  <= cur_div_d;
      cur_dur_q  <= cur_dur_d;
      half_cnt_q <= half_cnt_d;
      presc_q    <= presc_d;
      tick_cnt_q <= tick_cnt_d;
      note_idx_q <= note_idx_d;
      done_q     <= done_d;
      out_q      <= out_d;
    end
  end
endmodule

// File: tb/tb_note_sequencer.sv
// Testbench for note_sequencer: a note-level behavioural model compared every
// cycle, directed melodies with hand-computed expectations, then random traffic.
module tb_note_sequencer;
  localparam int N_NOTES  = 4;
  localparam int DIV_W    = 16;
  localparam int DUR_W    = 8;
  localparam int TICK_DIV = 4;
  localparam int IDX_W    = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  note_sequencer_if #(.N_NOTES(N_NOTES), .DIV_W(DIV_W), .DUR_W(DUR_W)) bus ();

  note_sequencer #(
    .N_NOTES (N_NOTES),
    .DIV_W   (DIV_W),
    .DUR_W   (DUR_W),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef enum {M_IDLE, M_LOAD, M_PLAY} mmode_t;

  mmode_t m_mode  = M_IDLE;
  int     m_idx   = 0;
  int     m_k     = 0;
  int     m_div   = 0;
  int     m_dur   = 0;
  bit     m_done  = 1'b0;
  bit     m_valid = 1'b0;
  int     mem_div [N_NOTES];
  int     mem_dur [N_NOTES];

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit st, input bit sp, input bit lp, input bit we,
                               input int addr, input int dv, input int du);
    bus.start    = st;
    bus.stop     = sp;
    bus.loop     = lp;
    bus.cfg_we   = we;
    bus.cfg_addr = IDX_W'(addr);
    bus.cfg_div  = DIV_W'(dv);
    bus.cfg_dur  = DUR_W'(du);
    @(posedge clk);
    #1;
  endtask

  // Expected buzzer level: k-th cycle of a note plays floor(k/div) mod 2.
  function automatic bit expOut();
    if (m_mode != M_PLAY || m_div == 0) return 1'b0;
`ifdef NOTE_GAP_EN
    if (m_dur >= 2 && m_k >= (m_dur - 1) * TICK_DIV) return 1'b0;
`endif
    return ((m_k / m_div) % 2) == 1;
  endfunction

  // Reference model: which note is playing and how many cycles into it.
  always @(posedge clk) begin
    bit ended;
    if (rst) begin
      m_mode  = M_IDLE;
      m_idx   = 0;
      m_k     = 0;
      m_done  = 1'b0;
      m_valid = 1'b1;
    end else begin
      ended  = 1'b0;
      m_done = 1'b0;
      if (bus.stop) begin
        m_mode = M_IDLE;
      end else begin
        case (m_mode)
          M_IDLE: if (bus.start) begin m_mode = M_LOAD; m_idx = 0; end
          M_LOAD: begin
            m_div = mem_div[m_idx];
            m_dur = mem_dur[m_idx];
            m_k   = 0;
            if (m_dur == 0) ended = 1'b1; else m_mode = M_PLAY;
          end
          M_PLAY: begin
            if (m_k == m_dur * TICK_DIV - 1) begin
              if (m_idx == N_NOTES - 1) ended = 1'b1;
              else begin m_idx++; m_mode = M_LOAD; end
            end else begin
              m_k++;
            end
          end
          default: m_mode = M_IDLE;
        endcase
        if (ended) begin
          if (bus.loop) begin m_idx = 0; m_mode = M_LOAD; end
          else begin m_mode = M_IDLE; m_done = 1'b1; end
        end
      end
    end
    if (bus.cfg_we) begin
      mem_div[bus.cfg_addr] = int'(bus.cfg_div);
      mem_dur[bus.cfg_addr] = int'(bus.cfg_dur);
    end
  end

  // Compare every output against the model once per cycle, mid-period.
  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("busy",     32'(bus.busy),     32'(m_mode != M_IDLE));
      checkOutput("note_idx", 32'(bus.note_idx), 32'(m_idx));
      checkOutput("done",     32'(bus.done),     32'(m_done));
      checkOutput("out",      32'(bus.out),      32'(expOut()));
    end
  end

  // Hand-derived waveform of the first demo melody, one entry per busy cycle.
`ifdef NOTE_GAP_EN
  int lit_out [20] = '{0, 0,0,0,1,0,0,0,0, 0, 0,0,0,0, 0, 0,0,1,1, 0};
`else
  int lit_out [20] = '{0, 0,0,0,1,1,1,0,0, 0, 0,0,0,0, 0, 0,0,1,1, 0};
`endif

  // Directed scenarios followed by randomized traffic.
  initial begin
    int done_cnt;
    bit seen_wrap;
    int prev_idx;
    rst = 1'b1;
    applyStimulus(0, 0, 0, 1, 0, 3, 2);
    applyStimulus(0, 0, 0, 1, 1, 0, 1);
    applyStimulus(0, 0, 0, 1, 2, 2, 1);
    applyStimulus(0, 0, 0, 1, 3, 0, 0);
    checkOutput("reset_busy", 32'(bus.busy), 0);
    checkOutput("reset_out",  32'(bus.out), 0);
    checkOutput("reset_done", 32'(bus.done), 0);
    checkOutput("reset_idx",  32'(bus.note_idx), 0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] demo melody, loop off");
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      checkOutput("demo_out", 32'(bus.out), 32'(lit_out[i]));
      checkOutput("demo_idx", 32'(bus.note_idx), (i < 9) ? 0 : (i < 14) ? 1 : (i < 19) ? 2 : 3);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
    end
    checkOutput("demo_done",      32'(bus.done), 1);
    checkOutput("demo_busy_end",  32'(bus.busy), 0);
    checkOutput("demo_idx_hold",  32'(bus.note_idx), 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("demo_done_once", 32'(bus.done), 0);

    $display("[TB] stop mid-note and stop+start together");
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("stop_busy", 32'(bus.busy), 0);
    checkOutput("stop_out",  32'(bus.out), 0);
    checkOutput("stop_done", 32'(bus.done), 0);
    checkOutput("stop_idx",  32'(bus.note_idx), 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkOutput("stopstart_busy", 32'(bus.busy), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("stopstart_stay", 32'(bus.busy), 0);

    $display("[TB] looping full table with start held and live writes");
    applyStimulus(0, 0, 1, 1, 0, 2, 1);
    applyStimulus(0, 0, 1, 1, 1, 1, 1);
    applyStimulus(0, 0, 1, 1, 2, 3, 1);
    applyStimulus(0, 0, 1, 1, 3, 0, 1);
    done_cnt  = 0;
    seen_wrap = 1'b0;
    prev_idx  = 0;
    for (int i = 0; i < 60; i++) begin
      if (i == 3) applyStimulus(1, 0, 1, 1, 2, 1, 2);
      else if (i == 4) applyStimulus(1, 0, 1, 1, 0, 1, 2);
      else applyStimulus(1, 0, 1, 0, 0, 0, 0);
      if (bus.done === 1'b1) done_cnt++;
      if (prev_idx == 3 && int'(bus.note_idx) == 0) seen_wrap = 1'b1;
      prev_idx = int'(bus.note_idx);
    end
    checkOutput("loop_no_done", 32'(done_cnt), 0);
    checkOutput("loop_wrapped", 32'(seen_wrap), 1);
    applyStimulus(1, 1, 1, 0, 0, 0, 0);
    checkOutput("loop_stopped", 32'(bus.busy), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3));
    end
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
